// File: rtl/iob_ram_responder.sv
// iob native-bus responder: serves one request at a time from an internal word RAM,
// answering WAIT_STATES+2 cycles after acceptance. Define IOB_RESP_WPROT_EN to write-protect low words.
`ifndef REQ_W
`define REQ_W (1+ADDR_W+DATA_W+(DATA_W/8))
`endif
`ifndef RESP_W
`define RESP_W (DATA_W+1)
`endif

module iob_ram_responder #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_ADDR_W  = 10,
  parameter int WAIT_STATES = 0,
  parameter int WPROT_WORDS = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [`REQ_W-1:0]  req,
  output logic [`RESP_W-1:0] resp,
  output logic               wprot_err
);

  // state  | meaning
  // IDLE   | ready for a request (also the cycle ready pulses)
  // WAIT   | counting down wait states on the latched request
  // ACCESS | RAM read or byte-masked write; answer next cycle
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  localparam int         STRB_W   = DATA_W / 8;
  localparam logic [7:0] WS_LOAD  = 8'(WAIT_STATES);
  localparam logic [1:0] ST_AFTER = (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;

  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_wstrb;

  assign {req_valid, req_addr, req_wdata, req_wstrb} = req;

  logic [1:0]            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [MEM_ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  ready_q, ready_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  wprot_q, wprot_d;
  logic                  mem_we;
  logic                  wr_blocked;

  logic [DATA_W-1:0] mem [0:(1<<MEM_ADDR_W)-1];

  // Only the word index bits select RAM; the rest of the address is don't-care.
  logic unused_addr;
  assign unused_addr = ^{req_addr[ADDR_W-1:MEM_ADDR_W+2], req_addr[1:0]};

`ifdef IOB_RESP_WPROT_EN
  assign wr_blocked = (32'(idx_q) < WPROT_WORDS);
`else
  logic unused_wprot;
  assign unused_wprot = (WPROT_WORDS != 0);
  assign wr_blocked   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    ready_d = 1'b0;
    rdata_d = '0;
    wprot_d = wprot_q;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          idx_d   = req_addr[MEM_ADDR_W+1:2];
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          cnt_d   = WS_LOAD;
          state_d = ST_AFTER;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
        if (wstrb_q == '0) begin
          rdata_d = mem[idx_q];
        end else if (wr_blocked) begin
          wprot_d = 1'b1;
        end else begin
          mem_we = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      wprot_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      wprot_q <= wprot_d;
    end
  end

  // RAM is not reset; a reset coinciding with the ACCESS edge cancels the write.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb_q[i]) begin
          mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign resp      = {rdata_q, ready_q};
  assign wprot_err = wprot_q;

endmodule

// File: doc/iob_ram_responder.md
Name: iob_ram_responder

Overview:
- Responder end of the iob native bus: accepts one request at a time from an initiator (CPU ibus/dbus or interconnect slave port) and serves it from an internal word-addressed RAM.
- Inserts a programmable number of wait states before answering, so initiator-side hold/replay logic is exercised.
- Sits behind the interconnect as a generic slave (boot SRAM or test memory).

Parameters:
- ADDR_W, 32, request address width.
- DATA_W, 32, data width; wstrb is DATA_W/8 bits.
- MEM_ADDR_W, 10, log2 of RAM depth in words.
- WAIT_STATES, 0, extra cycles between acceptance and memory access (0..255).
- WPROT_WORDS, 256, number of write-protected low words (used only with IOB_RESP_WPROT_EN).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- req  input  `REQ_W  {valid, addr[ADDR_W-1:0], wdata[DATA_W-1:0], wstrb[DATA_W/8-1:0]}; valid is the MSB and wstrb the LSBs.
- resp  output  `RESP_W  {rdata[DATA_W-1:0], ready}; ready is bit 0.
- wprot_err  output  1  sticky write-protection violation flag.

Behaviour:
- Protocol:
  - Initiator raises valid and holds valid/addr/wdata/wstrb until ready.
  - ready is a single-cycle pulse; rdata is meaningful only while ready=1.
  - In the cycle ready=1, the initiator may already present the next request.
- Request type:
  - wstrb != 0 is a write; byte lane i is written when wstrb[i]=1.
  - wstrb == 0 is a read.
- Word index is addr[MEM_ADDR_W+1:2]. Bits addr[1:0] and all upper bits are ignored; no range error is raised.
- FSM states: IDLE, WAIT, ACCESS.
  - IDLE: valid=1 accepts the request, latches addr/wdata/wstrb, and loads cnt=WAIT_STATES. Next state is ACCESS if WAIT_STATES==0, else WAIT.
  - WAIT: cnt decrements each cycle; go to ACCESS when cnt==1. Input changes are ignored because the latched copy is used.
  - ACCESS: performs the RAM read or byte-masked write. Next cycle drives ready=1.
    - Reads: rdata = RAM word.
    - Writes: rdata = 0.
    - If valid=1 in the ready cycle, that request is accepted immediately, as from IDLE (back-to-back, no idle gap). Otherwise return to IDLE.
- Latency: ready asserts exactly WAIT_STATES+2 cycles after the acceptance cycle.
- Read-after-write to the same word returns the new data. No bypass is needed because accesses are serialized.
- Reset values:
  - ready=0, rdata=0, state=IDLE, cnt=0, wprot_err=0.
  - RAM contents are not reset.
- Reset mid-operation: rst in WAIT or ACCESS aborts the transaction. The pending write is not performed if rst is sampled before the ACCESS write edge, and no ready is issued.
- valid deasserted by the initiator before ready (protocol violation): the transaction still completes and ready still pulses.
- At most one outstanding request; there is no queue.

Optional Feature:
- IOB_RESP_WPROT_EN.
- Defined:
  - Writes whose word index < WPROT_WORDS leave RAM unchanged.
  - The transaction is still acknowledged with normal latency and rdata=0.
  - wprot_err is set the cycle after the ACCESS state and stays set until rst.
  - Reads are unaffected.
- Undefined: all words are writable, wprot_err is tied to 0, and WPROT_WORDS is ignored.

Test Plan:
- WAIT_STATES=0: write addr=0x00000404, wdata=0xDEADBEEF, wstrb=0xF, then read 0x404.
  - ready 2 cycles after each acceptance.
  - Read returns 0xDEADBEEF; write returns rdata=0.
- Byte strobe: word 0x404=0xDEADBEEF, write wdata=0x00AA0000 with wstrb=0x4, then read.
  - Read returns 0xDEAABEEF.
- WAIT_STATES=3: single read of 0x10.
  - ready exactly 5 cycles after acceptance.
  - Changing addr during the wait does not change rdata.
- Back-to-back: hold valid across two reads (0x8, then 0xC presented in the first ready cycle).
  - Second ready exactly 2 cycles after the first (WAIT_STATES=0); no idle cycle.
- Reset mid-op: WAIT_STATES=4, write 0x20=0x12345678, assert rst for 1 cycle in the 2nd wait cycle.
  - No ready pulse; a subsequent read of 0x20 returns its prior value.
- IOB_RESP_WPROT_EN, WPROT_WORDS=256: write 0x3FC=0x55.
  - Acknowledged, RAM unchanged, wprot_err=1 sticky.
  - A write to 0x400 succeeds; wprot_err is cleared only by rst.
